// File: rtl/ula_pkg.sv
// rtl/ula_pkg.sv - shared constants and types for ula and ula_ctrl
//
// Purpose: selector encodings understood by the 8-bit ula, default datapath
// sizing, and the ula_ctrl sequencing state type.
// Ports: none (package).
package ula_pkg;

  localparam int ULA_W    = 8;
  localparam int ULA_NREG = 4;

  localparam logic [3:0] ULA_NOT = 4'd0;
  localparam logic [3:0] ULA_AND = 4'd1;
  localparam logic [3:0] ULA_OR  = 4'd2;
  localparam logic [3:0] ULA_XOR = 4'd3;
  localparam logic [3:0] ULA_ADD = 4'd4;
  localparam logic [3:0] ULA_SUB = 4'd5;
  localparam logic [3:0] ULA_SLR = 4'd6;
  localparam logic [3:0] ULA_SRR = 4'd7;
  localparam logic [3:0] ULA_MUL = 4'd8;
  localparam logic [3:0] ULA_ROL = 4'd9;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_CAPT  = 2'd2,
    ST_DONE  = 2'd3
  } ula_ctrl_state_t;

endpackage

// File: rtl/banco_reg.sv
// rtl/banco_reg.sv - NREG x W register bank, one write port, two async read ports
//
// Purpose: architectural registers R[0..NREG-1] for ula_ctrl.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset (clears all to 0)
//   we, waddr, wdata  write port, applied on the rising edge
//   raddr_a, rdata_a  combinational read port A
//   raddr_b, rdata_b  combinational read port B
module banco_reg
  import ula_pkg::*;
#(
  parameter int NREG = ULA_NREG,
  parameter int W    = ULA_W,
  localparam int AW  = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr_a,
  output logic [W-1:0]  rdata_a,
  input  logic [AW-1:0] raddr_b,
  output logic [W-1:0]  rdata_b
);

  logic [W-1:0] regs [NREG];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (we) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata_a = regs[raddr_a];
  assign rdata_b = regs[raddr_b];

endmodule

// File: rtl/ula_ctrl.sv
// rtl/ula_ctrl.sv - sequencing front end driving the 8-bit ula
//
// Purpose: holds R[0..3], accepts one operation per valid/ready handshake,
// drives ula operands, captures ula_S back into R[ra] and the zero flag.
// Build option: ULA_CTRL_MUL_EN - when defined selector 8 (MUL) is legal,
// otherwise it is rejected with an err pulse like 10..15.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   wr_en, wr_addr, wr_data    external register load (IDLE only)
//   op_valid, op_ready         request handshake
//   op_sel, op_ra, op_rb       selector, dest/first operand, second operand
//   ula_A, ula_B, ula_Seletor  registered operands/selector to the ula
//   ula_ZERO                   zero flag of the previous completed operation
//   ula_S                      ula result (combinational)
//   res_valid, res_data, res_zero  completion pulse, result, zero flag
//   err                        one-cycle pulse for an illegal selector
module ula_ctrl
  import ula_pkg::*;
#(
  parameter int NREG = ULA_NREG,
  parameter int W    = ULA_W,
  localparam int AW  = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [W-1:0]  wr_data,
  input  logic          op_valid,
  output logic          op_ready,
  input  logic [3:0]    op_sel,
  input  logic [AW-1:0] op_ra,
  input  logic [AW-1:0] op_rb,
  output logic [W-1:0]  ula_A,
  output logic [W-1:0]  ula_B,
  output logic [3:0]    ula_Seletor,
  output logic          ula_ZERO,
  input  logic [W-1:0]  ula_S,
  output logic          res_valid,
  output logic [W-1:0]  res_data,
  output logic          res_zero,
  output logic          err
);

  localparam logic [1:0] IDLE  = ST_IDLE;
  localparam logic [1:0] DRIVE = ST_DRIVE;
  localparam logic [1:0] CAPT  = ST_CAPT;
  localparam logic [1:0] DONE  = ST_DONE;

  logic [1:0]    state;
  logic [3:0]    sel_q;
  logic [AW-1:0] ra_q;
  logic [AW-1:0] rb_q;
  logic          zero_q;
  logic          rej_q;
  logic          sel_ok;

  logic          bank_we;
  logic [AW-1:0] bank_waddr;
  logic [W-1:0]  bank_wdata;
  logic [W-1:0]  rd_a;
  logic [W-1:0]  rd_b;

`ifdef ULA_CTRL_MUL_EN
  assign sel_ok = (op_sel <= ULA_ROL);
`else
  assign sel_ok = (op_sel <= ULA_ROL) && (op_sel != ULA_MUL);
`endif

  // Write-back in CAPT owns the write port; external loads only land in IDLE.
  assign bank_we    = (state == CAPT) || ((state == IDLE) && wr_en);
  assign bank_waddr = (state == CAPT) ? ra_q  : wr_addr;
  assign bank_wdata = (state == CAPT) ? ula_S : wr_data;

  banco_reg #(
    .NREG (NREG),
    .W    (W)
  ) u_bank (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (bank_we),
    .waddr   (bank_waddr),
    .wdata   (bank_wdata),
    .raddr_a (ra_q),
    .rdata_a (rd_a),
    .raddr_b (rb_q),
    .rdata_b (rd_b)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      sel_q       <= '0;
      ra_q        <= '0;
      rb_q        <= '0;
      zero_q      <= 1'b0;
      rej_q       <= 1'b0;
      err         <= 1'b0;
      ula_A       <= '0;
      ula_B       <= '0;
      ula_Seletor <= '0;
      res_data    <= '0;
    end else begin
      // A rejected request is noted at its acceptance edge and reported one
      // edge later, so err never blocks a back-to-back request.
      err   <= rej_q;
      rej_q <= 1'b0;
      case (state)
        IDLE: begin
          if (op_valid) begin
            sel_q <= op_sel;
            ra_q  <= op_ra;
            rb_q  <= op_rb;
            if (sel_ok) state <= DRIVE;
            else        rej_q <= 1'b1;
          end
        end
        DRIVE: begin
          // Reads happen here so a same-cycle IDLE load is already visible.
          ula_A       <= rd_a;
          ula_B       <= rd_b;
          ula_Seletor <= sel_q;
          state       <= CAPT;
        end
        CAPT: begin
          res_data <= ula_S;
          zero_q   <= (ula_S == '0);
          state    <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign op_ready  = (state == IDLE);
  assign res_valid = (state == DONE);
  assign ula_ZERO  = zero_q;
  assign res_zero  = zero_q;

endmodule
